btb_2way: RTL and testbench
===========================

Name: btb_2way

Overview:
- Branch target buffer in the fetch stage. Predicts next PC, taken bit and prediction-valid bit for the fetch PC.
- Trained by the MEM-stage branch/jump resolver through its update interface: update enable, resolved target, instruction PC, actual outcome.
- Organisation: 2-way set-associative, 8 sets, 2-bit saturating direction counter per entry, 1 LRU bit per set.

Parameters:
- SETS, 8, number of sets (power of 2, >=2); INDEX_W = log2(SETS).
- TAG_W, 32-2-INDEX_W, tag width, taken from pc[31:2+INDEX_W].

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous invalidate of all entries
- fetch_pc  in  32  PC being fetched
- pred_valid  out  1  fetch_pc hit in BTB
- predicted_pc  out  32  predicted next PC
- predicted_taken  out  1  predicted direction
- upd_en  in  1  resolver update strobe (branch or jump in MEM)
- upd_pc  in  32  PC of resolved instruction
- upd_target  in  32  resolved target (already LSB-masked for JALR)
- upd_taken  in  1  actual outcome (1 for any jump)
- upd_is_jump  in  1  JAL/JALR

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low. On reset all valid bits = 0, all LRU bits = 0, counters = 2'b01, tags/targets = 0.
- Index = pc[2+INDEX_W-1:2]; tag = pc[31:2+INDEX_W]. pc[1:0] ignored.
- Lookup (combinational, zero latency from fetch_pc):
  - Hit when a way has valid && tag match.
  - Hit: pred_valid=1, predicted_pc=target of hit way, predicted_taken=counter[1].
  - Miss: pred_valid=0, predicted_pc=fetch_pc+4 (mod 2^32), predicted_taken=0.
  - Both ways matching is impossible by construction. If it occurs, way 0 has priority.
  - Outputs under reset: pred_valid=0, predicted_taken=0, predicted_pc=fetch_pc+4.
- Update (registered, effective the cycle after upd_en is sampled high):
  - Hit in way w: target[w] <= upd_target.
    - Jump: counter <= 2'b11.
    - Branch taken: counter <= min(counter+1, 3).
    - Branch not-taken: counter <= max(counter-1, 0).
    - LRU[set] <= ~w.
  - Miss: victim = way 0 if invalid, else way 1 if invalid, else LRU[set]. Write valid=1, tag, target.
    - Counter = 2'b11 for a jump, 2'b10 for branch taken, 2'b01 for branch not-taken.
    - LRU[set] <= ~victim.
    - Not-taken branches are allocated, so the target is available for later taken predictions.
- LRU changes only on updates, never on lookups.
- Simultaneous lookup and update to the same set/tag in one cycle: lookup returns pre-update contents. No write-to-read bypass.
- flush: clears all valid bits at the next edge. LRU, counters and targets are untouched.
- flush && upd_en in the same cycle: flush wins; no entry is written.
- rst_n asserted mid-operation: state clears immediately; any pending update is lost.
- Addition wraps: fetch_pc=32'hFFFF_FFFC on a miss gives predicted_pc=32'h0000_0000.

Decomposition:
- Package btb_pkg holds:
  - constants BTB_SETS, BTB_INDEX_W, BTB_TAG_W;
  - typedef btb_entry_t {valid, tag, target[31:0], ctr[1:0]};
  - localparams CTR_SNT=2'b00, CTR_WNT=2'b01, CTR_WT=2'b10, CTR_ST=2'b11;
  - functions sat_inc/sat_dec.
- One sub-module, btb_way: a SETS-deep entry array with combinational read at index, synchronous write port and flush.
- btb_2way instantiates two btb_way and owns the LRU vector, hit/victim logic and counter update.

Test Plan:
- Reset, then fetch_pc=32'h0000_0100 -> pred_valid=0, predicted_pc=32'h0000_0104, predicted_taken=0.
- Update upd_pc=32'h100, upd_target=32'h200, taken=1, branch. Next cycle fetch 32'h100 -> pred_valid=1, predicted_pc=32'h200, predicted_taken=1 (ctr=10).
  - Then two not-taken updates -> ctr 01 then 00, predicted_taken=0, pred_valid=1.
  - Then three taken updates -> ctr saturates at 11.
- Jump update upd_pc=32'h40, upd_target=32'h1000, is_jump=1 -> ctr=11, predicted_taken=1. Update with target 32'h2000 -> predicted_pc=32'h2000.
- Set-conflict eviction:
  - Allocate 32'h100, then 32'h120, both in set 0 with SETS=8 → ways 0 and 1.
  - Update 32'h140: LRU was last set by 32'h120's update, so way 0 (32'h100) is evicted.
  - Fetch 32'h100 then misses; 32'h120 and 32'h140 hit.
- Same-cycle lookup and update of 32'h300 -> that cycle pred_valid=0, next cycle pred_valid=1.
  - flush together with upd_en -> all lookups miss and the update is dropped.
- Assert rst_n low for one cycle between two updates -> all entries miss; fetch_pc=32'hFFFF_FFFC gives predicted_pc=32'h0.

Source files
------------

// File: rtl/btb_pkg.sv
// Shared types, sizing constants and counter helpers for the 2-way branch target buffer.
// Entries hold the widest possible tag so any legal SETS value fits in one struct.
package btb_pkg;

    localparam int BTB_SETS      = 8;
    localparam int BTB_INDEX_W   = $clog2(BTB_SETS);
    localparam int BTB_TAG_W     = 32 - 2 - BTB_INDEX_W;
    localparam int BTB_TAG_MAX_W = 29;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    typedef struct packed {
        logic                     valid;
        logic [BTB_TAG_MAX_W-1:0] tag;
        logic [31:0]              target;
        logic [1:0]               ctr;
    } btb_entry_t;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == CTR_ST) ? CTR_ST : c + 2'b01;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == CTR_SNT) ? CTR_SNT : c - 2'b01;
    endfunction

endpackage

// File: rtl/btb_way.sv
// One way of the BTB: SETS-deep entry array with two combinational read ports,
// one synchronous write port and a flush that clears only the valid bits.
module btb_way
    import btb_pkg::*;
#(
    parameter int SETS    = BTB_SETS,
    parameter int INDEX_W = $clog2(SETS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic [INDEX_W-1:0] lk_idx,
    output btb_entry_t         lk_entry,
    input  logic [INDEX_W-1:0] up_idx,
    output btb_entry_t         up_entry,
    input  logic               wr_en,
    input  btb_entry_t         wr_entry
);

    localparam btb_entry_t RESET_ENTRY = '{valid: 1'b0, tag: '0, target: 32'h0, ctr: CTR_WNT};

    btb_entry_t mem_q [SETS];
    btb_entry_t mem_d [SETS];

    always_comb begin
        mem_d = mem_q;
        if (flush) begin
            for (int i = 0; i < SETS; i++) begin
                mem_d[i].valid = 1'b0;
            end
        end else if (wr_en) begin
            mem_d[up_idx] = wr_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SETS; i++) begin
                mem_q[i] <= RESET_ENTRY;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign lk_entry = mem_q[lk_idx];
    assign up_entry = mem_q[up_idx];

endmodule

// File: rtl/btb_2way.sv
// 2-way set-associative branch target buffer: zero-latency lookup for fetch,
// trained one cycle later by the resolver with per-set LRU replacement.
module btb_2way
    import btb_pkg::*;
#(
    parameter int SETS = BTB_SETS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic [31:0] fetch_pc,
    output logic        pred_valid,
    output logic [31:0] predicted_pc,
    output logic        predicted_taken,
    input  logic        upd_en,
    input  logic [31:0] upd_pc,
    input  logic [31:0] upd_target,
    input  logic        upd_taken,
    input  logic        upd_is_jump
);

    localparam int INDEX_W = $clog2(SETS);

    logic [INDEX_W-1:0]       fetch_idx, upd_idx;
    logic [31:0]              fetch_shift, upd_shift;
    logic [BTB_TAG_MAX_W-1:0] fetch_tag, upd_tag;

    btb_entry_t lk_entry [2];
    btb_entry_t up_entry [2];
    btb_entry_t wr_entry;
    logic [1:0] wr_en;

    logic [SETS-1:0] lru_q, lru_d;

    logic       lk_hit0, lk_hit1;
    logic       up_hit0, up_hit1, up_hit;
    logic       hit_way, victim_way, sel_way;
    logic [1:0] cur_ctr, new_ctr;
    logic       do_update;

    // Tags are the PC bits above the index, zero-extended to the struct's tag width.
    assign fetch_idx   = fetch_pc[2 +: INDEX_W];
    assign upd_idx     = upd_pc[2 +: INDEX_W];
    assign fetch_shift = fetch_pc >> (2 + INDEX_W);
    assign upd_shift   = upd_pc >> (2 + INDEX_W);
    assign fetch_tag   = fetch_shift[BTB_TAG_MAX_W-1:0];
    assign upd_tag     = upd_shift[BTB_TAG_MAX_W-1:0];

    for (genvar w = 0; w < 2; w++) begin : g_way
        btb_way #(
            .SETS    (SETS),
            .INDEX_W (INDEX_W)
        ) u_way (
            .clk      (clk),
            .rst_n    (rst_n),
            .flush    (flush),
            .lk_idx   (fetch_idx),
            .lk_entry (lk_entry[w]),
            .up_idx   (upd_idx),
            .up_entry (up_entry[w]),
            .wr_en    (wr_en[w]),
            .wr_entry (wr_entry)
        );
    end

    assign lk_hit0 = lk_entry[0].valid && (lk_entry[0].tag == fetch_tag);
    assign lk_hit1 = lk_entry[1].valid && (lk_entry[1].tag == fetch_tag);

    // Way 0 wins if both ways ever match.
    always_comb begin
        pred_valid      = 1'b0;
        predicted_pc    = fetch_pc + 32'd4;
        predicted_taken = 1'b0;
        if (lk_hit0) begin
            pred_valid      = 1'b1;
            predicted_pc    = lk_entry[0].target;
            predicted_taken = lk_entry[0].ctr[1];
        end else if (lk_hit1) begin
            pred_valid      = 1'b1;
            predicted_pc    = lk_entry[1].target;
            predicted_taken = lk_entry[1].ctr[1];
        end
    end

    assign up_hit0   = up_entry[0].valid && (up_entry[0].tag == upd_tag);
    assign up_hit1   = up_entry[1].valid && (up_entry[1].tag == upd_tag);
    assign up_hit    = up_hit0 || up_hit1;
    assign hit_way   = !up_hit0;
    assign do_update = upd_en && !flush;

    always_comb begin
        victim_way = lru_q[upd_idx];
        if (!up_entry[0].valid) begin
            victim_way = 1'b0;
        end else if (!up_entry[1].valid) begin
            victim_way = 1'b1;
        end
        sel_way = up_hit ? hit_way : victim_way;
        cur_ctr = hit_way ? up_entry[1].ctr : up_entry[0].ctr;

        new_ctr = CTR_WNT;
        if (upd_is_jump) begin
            new_ctr = CTR_ST;
        end else if (up_hit) begin
            new_ctr = upd_taken ? sat_inc(cur_ctr) : sat_dec(cur_ctr);
        end else begin
            new_ctr = upd_taken ? CTR_WT : CTR_WNT;
        end

        wr_entry = '{valid: 1'b1, tag: upd_tag, target: upd_target, ctr: new_ctr};
        wr_en[0] = do_update && (sel_way == 1'b0);
        wr_en[1] = do_update && (sel_way == 1'b1);

        lru_d = lru_q;
        if (do_update) begin
            lru_d[upd_idx] = ~sel_way;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lru_q <= '0;
        end else begin
            lru_q <= lru_d;
        end
    end

endmodule

// File: tb/tb_btb_2way.sv
// Directed self-checking bench for btb_2way: training, saturation, jumps,
// LRU eviction, same-cycle lookup/update, flush and asynchronous reset.
module tb_btb_2way;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic [31:0] fetch_pc;
   logic        pred_valid;
   logic [31:0] predicted_pc;
   logic        predicted_taken;
   logic        upd_en;
   logic [31:0] upd_pc;
   logic [31:0] upd_target;
   logic        upd_taken;
   logic        upd_is_jump;

   int checks = 0;
   int errors = 0;

   btb_2way dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .flush           (flush),
      .fetch_pc        (fetch_pc),
      .pred_valid      (pred_valid),
      .predicted_pc    (predicted_pc),
      .predicted_taken (predicted_taken),
      .upd_en          (upd_en),
      .upd_pc          (upd_pc),
      .upd_target      (upd_target),
      .upd_taken       (upd_taken),
      .upd_is_jump     (upd_is_jump)
   );

   // Free-running 10-unit clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drive one resolver update at the falling edge so it is sampled at the next rising edge
   task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] target,
                                input logic taken, input logic isJump);
      @(negedge clk);
      upd_en      = 1'b1;
      upd_pc      = pc;
      upd_target  = target;
      upd_taken   = taken;
      upd_is_jump = isJump;
      @(posedge clk);
      #1;
      upd_en      = 1'b0;
   endtask

   // Present a fetch PC and compare all three prediction outputs
   task automatic checkOutput(input string name, input logic [31:0] pc, input logic expValid,
                              input logic [31:0] expPc, input logic expTaken);
      fetch_pc = pc;
      #1;
      checks++;
      assert (pred_valid === expValid) else begin
         errors++;
         $error("[TB] FAIL %s pred_valid: observed %b expected %b", name, pred_valid, expValid);
      end
      checks++;
      assert (predicted_pc === expPc) else begin
         errors++;
         $error("[TB] FAIL %s predicted_pc: observed %h expected %h", name, predicted_pc, expPc);
      end
      checks++;
      assert (predicted_taken === expTaken) else begin
         errors++;
         $error("[TB] FAIL %s predicted_taken: observed %b expected %b", name, predicted_taken, expTaken);
      end
   endtask

   // Pulse reset low for one full cycle, leaving the bench just after the release
   task automatic pulseReset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
   endtask

   // Directed sequence of training and lookup steps
   initial begin
      rst_n       = 1'b0;
      flush       = 1'b0;
      fetch_pc    = 32'h0;
      upd_en      = 1'b0;
      upd_pc      = 32'h0;
      upd_target  = 32'h0;
      upd_taken   = 1'b0;
      upd_is_jump = 1'b0;
      #2;
      checkOutput("in_reset", 32'h0000_0100, 1'b0, 32'h0000_0104, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      checkOutput("after_reset", 32'h0000_0100, 1'b0, 32'h0000_0104, 1'b0);

      applyStimulus(32'h100, 32'h200, 1'b1, 1'b0);
      checkOutput("alloc_taken", 32'h100, 1'b1, 32'h200, 1'b1);
      applyStimulus(32'h100, 32'h200, 1'b0, 1'b0);
      checkOutput("nt_to_01", 32'h100, 1'b1, 32'h200, 1'b0);
      applyStimulus(32'h100, 32'h200, 1'b0, 1'b0);
      checkOutput("nt_to_00", 32'h100, 1'b1, 32'h200, 1'b0);
      applyStimulus(32'h100, 32'h200, 1'b1, 1'b0);
      checkOutput("t_to_01", 32'h100, 1'b1, 32'h200, 1'b0);
      applyStimulus(32'h100, 32'h200, 1'b1, 1'b0);
      checkOutput("t_to_10", 32'h100, 1'b1, 32'h200, 1'b1);
      applyStimulus(32'h100, 32'h200, 1'b1, 1'b0);
      checkOutput("t_to_11", 32'h100, 1'b1, 32'h200, 1'b1);
      applyStimulus(32'h100, 32'h200, 1'b0, 1'b0);
      checkOutput("sat_then_nt", 32'h100, 1'b1, 32'h200, 1'b1);

      applyStimulus(32'h40, 32'h1000, 1'b1, 1'b1);
      checkOutput("jump_alloc", 32'h40, 1'b1, 32'h1000, 1'b1);
      applyStimulus(32'h40, 32'h2000, 1'b1, 1'b1);
      checkOutput("jump_retarget", 32'h40, 1'b1, 32'h2000, 1'b1);
      checkOutput("other_way_kept", 32'h100, 1'b1, 32'h200, 1'b1);

      pulseReset();
      applyStimulus(32'h100, 32'h500, 1'b1, 1'b0);
      applyStimulus(32'h120, 32'h600, 1'b0, 1'b0);
      checkOutput("evict_pre_100", 32'h100, 1'b1, 32'h500, 1'b1);
      checkOutput("evict_pre_120", 32'h120, 1'b1, 32'h600, 1'b0);
      applyStimulus(32'h140, 32'h700, 1'b1, 1'b0);
      checkOutput("evict_100", 32'h100, 1'b0, 32'h104, 1'b0);
      checkOutput("evict_120", 32'h120, 1'b1, 32'h600, 1'b0);
      checkOutput("evict_140", 32'h140, 1'b1, 32'h700, 1'b1);

      pulseReset();
      @(negedge clk);
      upd_en      = 1'b1;
      upd_pc      = 32'h300;
      upd_target  = 32'h800;
      upd_taken   = 1'b1;
      upd_is_jump = 1'b0;
      checkOutput("same_cycle_pre", 32'h300, 1'b0, 32'h304, 1'b0);
      @(posedge clk);
      #1;
      upd_en = 1'b0;
      checkOutput("same_cycle_post", 32'h300, 1'b1, 32'h800, 1'b1);

      @(negedge clk);
      flush       = 1'b1;
      upd_en      = 1'b1;
      upd_pc      = 32'h500;
      upd_target  = 32'h900;
      upd_taken   = 1'b1;
      upd_is_jump = 1'b1;
      @(posedge clk);
      #1;
      flush  = 1'b0;
      upd_en = 1'b0;
      checkOutput("flush_clears", 32'h300, 1'b0, 32'h304, 1'b0);
      checkOutput("flush_drops_upd", 32'h500, 1'b0, 32'h504, 1'b0);

      applyStimulus(32'h100, 32'h200, 1'b1, 1'b0);
      checkOutput("pre_rst_hit", 32'h100, 1'b1, 32'h200, 1'b1);
      @(negedge clk);
      rst_n = 1'b0;
      checkOutput("rst_async_miss", 32'h100, 1'b0, 32'h104, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      checkOutput("post_rst_miss", 32'h100, 1'b0, 32'h104, 1'b0);
      checkOutput("wrap_pc", 32'hFFFF_FFFC, 1'b0, 32'h0000_0000, 1'b0);
      applyStimulus(32'h180, 32'hA00, 1'b0, 1'b0);
      checkOutput("post_rst_alloc", 32'h180, 1'b1, 32'hA00, 1'b0);
      checkOutput("post_rst_old", 32'h100, 1'b0, 32'h104, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
